// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
// Covers the read FSM states and the skid-buffer pointer and occupancy types.
package fifo_stream_reader_pkg;

   localparam int DEFAULT_FIFO_WIDTH = 16;
   localparam int DEFAULT_CNT_WIDTH  = 16;
   localparam int SKID_DEPTH         = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   typedef logic [1:0] skid_ptr_t;
   typedef logic [1:0] occ_t;

   localparam skid_ptr_t PTR_LAST = 2'd2;

   function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
      return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
   endfunction

   // Buffered words plus the word already requested must fit in the skid buffer.
   function automatic logic has_credit(input occ_t occ, input logic inflight);
      return ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying FIFO words.
// The master drives valid and data, and the slave drives ready.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 16
);
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_rd_skid_buf.sv
// Three-entry register FIFO that absorbs words returning from the FIFO read port.
// The head entry is presented directly as registered stream data.
module rd_skid_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = DEFAULT_FIFO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output occ_t             occ
);

   logic [WIDTH-1:0] mem_q [SKID_DEPTH];
   skid_ptr_t        head_q;
   skid_ptr_t        tail_q;
   occ_t             occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the entries are cleared along with the pointers so m_data reads zero after reset.
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push) begin
            mem_q[tail_q] <= push_data;
            tail_q        <= ptr_inc(tail_q);
         end
         if (pop) head_q <= ptr_inc(head_q);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_data = mem_q[head_q];
   assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO. It issues credit-limited reads and drains words
// through a skid buffer onto a valid/ready stream. It also flags FIFO underflow and counts delivered words.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
   parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   fifo_stream_reader_if.master  strm,
   input  logic                  err_clr,
   output logic                  underflow_err,
   output logic [CNT_WIDTH-1:0]  words_read,
   output logic                  busy
);

   rd_state_e             state_q;
   rd_state_e             state_d;
   logic                  inflight_q;
   occ_t                  occ;
   logic [FIFO_WIDTH-1:0] head_data;
   logic                  pop;

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned and infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = (occ != '0 || inflight_q) ? DRAIN : IDLE;
         DRAIN: begin
            if (enable)                           state_d = RUN;
            else if (occ == '0 && !inflight_q)   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read credit comes from registered state only, so m_ready has no combinational path to fifo_rd_en.
   always_comb begin
      fifo_rd_en = (state_q == RUN) && !fifo_empty && has_credit(occ, inflight_q);
      busy       = (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q    <= 1'b0;
         underflow_err <= 1'b0;
         words_read    <= '0;
      end else begin
         inflight_q <= fifo_rd_en;
         if (fifo_underflow) underflow_err <= 1'b1;
         else if (err_clr)   underflow_err <= 1'b0;
         if (pop) words_read <= words_read + 1'b1;
      end
   end

   assign pop          = strm.m_valid & strm.m_ready;
   assign strm.m_valid = (occ != '0);
   assign strm.m_data  = head_data;

   // A word returns on fifo_data_out one cycle after its read request was accepted.
   rd_skid_buf #(.WIDTH(FIFO_WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (fifo_data_out),
      .pop       (pop),
      .head_data (head_data),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. It pairs a queue-based FIFO model with a scoreboard
// of words read from it, runs directed scenarios, and then applies a randomized traffic phase.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        fifo_empty = 1'b1;
   logic        fifo_underflow;
   logic [15:0] fifo_data_out = '0;
   logic        fifo_rd_en;
   logic        err_clr;
   logic        underflow_err;
   logic [15:0] words_read;
   logic        busy;

   fifo_stream_reader_if #(.WIDTH(16)) strm ();

   fifo_stream_reader dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_data_out  (fifo_data_out),
      .fifo_rd_en     (fifo_rd_en),
      .strm           (strm),
      .err_clr        (err_clr),
      .underflow_err  (underflow_err),
      .words_read     (words_read),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] src_q[$];
   logic [15:0] sb_q[$];
   logic        rd_s = 1'b0;
   logic        rst_s = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: an accepted read pops the queue and presents the word in the following cycle.
   // Words popped and not yet delivered are what the reader owes downstream.
   always @(posedge clk) begin
      #1;
      if (rd_s) begin
         fifo_data_out = src_q.pop_front();
         sb_q.push_back(fifo_data_out);
      end else begin
         fifo_data_out = 16'($urandom);
      end
      if (rst_s) sb_q.delete();
      fifo_empty = (src_q.size() == 0);
   end

   // Monitor: compares outputs against the model.
   logic [15:0] mon_cnt = '0;
   logic        err_m = 1'b0;
   logic        rst_prev = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   always @(negedge clk) begin
      logic [15:0] exp_w;
      if (rst_prev) begin
         check("post_rst_m_valid", strm.m_valid, 0);
         check("post_rst_m_data", strm.m_data, 0);
         check("post_rst_rd_en", fifo_rd_en, 0);
         check("post_rst_busy", busy, 0);
      end
      check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      check("outstanding_le_3", sb_q.size() <= 3, 1);
      check("words_read", words_read, mon_cnt);
      check("underflow_err", underflow_err, err_m);
      if (prev_stall && !rst_prev) begin
         check("hold_valid", strm.m_valid, 1);
         check("hold_data", strm.m_data, prev_data);
      end
      if (strm.m_valid && strm.m_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", strm.m_data, $time);
         end else begin
            exp_w = sb_q.pop_front();
            check("stream_data", strm.m_data, exp_w);
         end
         mon_cnt++;
      end
      if (rst) begin
         mon_cnt = '0;
         err_m   = 1'b0;
      end else if (fifo_underflow) begin
         err_m = 1'b1;
      end else if (err_clr) begin
         err_m = 1'b0;
      end
      prev_stall = strm.m_valid && !strm.m_ready && !rst;
      prev_data  = strm.m_data;
      rd_s       = fifo_rd_en;
      rst_s      = rst;
      rst_prev   = rst;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drained(input string name, input int budget);
      int i = 0;
      while (!(src_q.size() == 0 && sb_q.size() == 0) && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, i < budget, 1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i = 0;
      while (busy && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, i < budget, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic rd_hist[14];
      logic v_hist[14];
      int   first_rd, last_rd, n_rd, first_v, last_v, n_v;

      // Reset applied while the FIFO holds words and enable is high.
      rst            = 1'b1;
      enable         = 1'b1;
      strm.m_ready   = 1'b1;
      fifo_underflow = 1'b0;
      err_clr        = 1'b0;
      for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
      tick(); tick(); tick();
      @(negedge clk);
      check("t1_rd_en", fifo_rd_en, 0);
      check("t1_m_valid", strm.m_valid, 0);
      check("t1_busy", busy, 0);
      check("t1_words_read", words_read, 0);
      tick();
      rst    = 1'b0;
      enable = 1'b0;
      tick(); tick();

      // Back-to-back streaming of a preloaded FIFO.
      enable = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rd_hist[i] = fifo_rd_en;
         v_hist[i]  = strm.m_valid;
      end
      first_rd = -1; last_rd = -1; n_rd = 0; first_v = -1; last_v = -1; n_v = 0;
      for (int i = 0; i < 14; i++) begin
         if (rd_hist[i]) begin
            if (first_rd < 0) first_rd = i;
            last_rd = i;
            n_rd++;
         end
         if (v_hist[i]) begin
            if (first_v < 0) first_v = i;
            last_v = i;
            n_v++;
         end
      end
      check("t2_rd_pulses", n_rd, 8);
      check("t2_rd_span", last_rd - first_rd + 1, 8);
      check("t2_latency", first_v - first_rd, 2);
      check("t2_valid_cycles", n_v, 8);
      check("t2_valid_span", last_v - first_v + 1, 8);
      check("t2_words_read", words_read, 8);
      check("t2_busy_run", busy, 1);

      // Backpressure: at most three reads, with the head word held steady.
      tick();
      strm.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) src_q.push_back(16'h0101 + 16'(i));
      n_rd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (fifo_rd_en) n_rd++;
      end
      check("t3_rd_pulses", n_rd, 3);
      check("t3_head_data", strm.m_data, 16'h0101);
      tick();
      strm.m_ready = 1'b1;
      wait_drained("t3_drain_timeout", 60);

      // Drop enable with a full buffer, then drain to IDLE.
      tick();
      strm.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) src_q.push_back(16'h0200 + 16'(i));
      n_rd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fifo_rd_en) n_rd++;
      end
      check("t4_rd_pulses", n_rd, 3);
      tick();
      enable = 1'b0;
      n_rd = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (fifo_rd_en) n_rd++;
      end
      check("t4_no_rd_after_disable", n_rd, 0);
      check("t4_busy_drain", busy, 1);
      tick();
      strm.m_ready = 1'b1;
      wait_idle("t4_idle_timeout", 20);
      check("t4_buffer_empty", sb_q.size(), 0);
      check("t4_remaining_in_fifo", src_q.size(), 5);
      tick();
      enable = 1'b1;
      wait_drained("t4_rest_timeout", 40);

      // Sticky underflow flag; set wins over clear.
      tick();
      enable         = 1'b0;
      fifo_underflow = 1'b1;
      tick();
      fifo_underflow = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("t5_err_set", underflow_err, 1);
      tick();
      fifo_underflow = 1'b1;
      err_clr        = 1'b1;
      tick();
      fifo_underflow = 1'b0;
      err_clr        = 1'b0;
      @(negedge clk);
      check("t5_err_set_wins", underflow_err, 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("t5_err_cleared", underflow_err, 0);

      // Reset with two words buffered and one in flight.
      tick();
      enable       = 1'b1;
      strm.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) src_q.push_back(16'h0300 + 16'(i));
      n_rd = 0;
      for (int i = 0; i < 20 && n_rd < 3; i++) begin
         @(negedge clk);
         if (fifo_rd_en) n_rd++;
      end
      check("t6_three_reads", n_rd, 3);
      tick();
      rst    = 1'b1;
      enable = 1'b0;
      tick();
      rst          = 1'b0;
      strm.m_ready = 1'b1;
      @(negedge clk);
      check("t6_m_valid", strm.m_valid, 0);
      check("t6_words_read", words_read, 0);
      n_v = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (strm.m_valid) n_v++;
      end
      check("t6_nothing_delivered", n_v, 0);
      tick();
      enable = 1'b1;
      wait_drained("t6_rest_timeout", 40);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         tick();
         if ($urandom_range(0, 2) == 0 && src_q.size() < 20) src_q.push_back(16'($urandom));
         strm.m_ready   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) enable = ~enable;
         fifo_underflow = ($urandom_range(0, 39) == 0);
         err_clr        = ($urandom_range(0, 24) == 0);
         rst            = ($urandom_range(0, 149) == 0);
      end
      tick();
      rst            = 1'b0;
      fifo_underflow = 1'b0;
      err_clr        = 1'b0;
      enable         = 1'b1;
      strm.m_ready   = 1'b1;
      wait_drained("final_drain_timeout", 100);
      tick();
      enable = 1'b0;
      wait_idle("final_idle_timeout", 20);
      check("final_m_valid", strm.m_valid, 0);
      check("final_scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
